// File: rtl/fpu_dmem_responder.sv
// FP load/store data-memory responder.
// Stores retire in the accepting cycle; loads return a fixed READ_LATENCY
// edges later together with the destination register and writeback enable.
// While a load is in flight, busy stalls the MEM stage.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | accepting requests; stores write immediately, loads are captured
// WAIT  | load outstanding; latency counter running down, requests ignored
module fpu_dmem_responder #(
    parameter int DEPTH_WORDS  = 256,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        mem_we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd_in,
    input  logic        wb_en_in,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic [4:0]  ld_rd,
    output logic        ld_wb_en,
    output logic        busy,
    output logic        addr_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    // READ_LATENCY tops out at 8, so the reload value never exceeds 7.
    localparam int CW = 3;
    localparam logic [CW-1:0] CNT_INIT = CW'(READ_LATENCY - 1);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [31:0]     mem [DEPTH_WORDS];

    logic [AW-1:0]   idx;
    logic [AW-1:0]   cap_idx_q;
    logic [4:0]      cap_rd_q;
    logic            cap_wb_q;

    logic            legal;
    logic            do_write;
    logic            do_capture;
    logic            do_resp;
    logic            err_d;

    // Word index and legality; anything above the array or off a word boundary is rejected.
    assign idx   = addr[AW+1:2];
    assign legal = (addr[1:0] == 2'b00) && (addr[31:AW+2] == '0);

    assign busy  = (state_q == WAIT);

    // Next-state and per-cycle strobes; WAIT deliberately ignores mem_en.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        do_write   = 1'b0;
        do_capture = 1'b0;
        do_resp    = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_en) begin
                    if (!legal) begin
                        err_d = 1'b1;
                    end else if (mem_we) begin
                        do_write = 1'b1;
                    end else begin
                        do_capture = 1'b1;
                        cnt_d      = CNT_INIT;
                        state_d    = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    do_resp = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register and latency down-counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Load context held for the duration of WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_idx_q <= '0;
            cap_rd_q  <= '0;
            cap_wb_q  <= 1'b0;
        end else if (do_capture) begin
            cap_idx_q <= idx;
            cap_rd_q  <= rd_in;
            cap_wb_q  <= wb_en_in;
        end
    end

    // Response registers: pulses clear every edge, payload holds until the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_valid <= 1'b0;
            ld_data  <= '0;
            ld_rd    <= '0;
            ld_wb_en <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            ld_valid <= do_resp;
            addr_err <= err_d;
            if (do_resp) begin
                ld_data  <= mem[cap_idx_q];
                ld_rd    <= cap_rd_q;
                ld_wb_en <= cap_wb_q;
            end
        end
    end

    // Storage array; not reset so contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[idx] <= wdata;
        end
    end

endmodule

// File: tb/tb_fpu_dmem_responder.sv
// Directed bench for fpu_dmem_responder at READ_LATENCY 1, 2 and 8.
// Load expectations (data, rd, wb_en, due cycle) are queued when the load is
// driven and matched against every ld_valid pulse.
module tb_fpu_dmem_responder;

    logic clk = 1'b0;
    logic rst;

    logic [2:0]       mem_en_v, mem_we_v, wb_en_v;
    logic [2:0][31:0] addr_v, wdata_v;
    logic [2:0][4:0]  rd_v;
    logic [2:0]       ld_valid_v, ld_wb_en_v, busy_v, addr_err_v;
    logic [2:0][31:0] ld_data_v;
    logic [2:0][4:0]  ld_rd_v;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int          k;
        int          due;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        wb;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    // Counts rising edges so due cycles can be compared at the falling edge.
    always @(posedge clk) cyc <= cyc + 1;

    fpu_dmem_responder #(.DEPTH_WORDS(256), .READ_LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .mem_en(mem_en_v[0]), .mem_we(mem_we_v[0]),
        .addr(addr_v[0]), .wdata(wdata_v[0]), .rd_in(rd_v[0]), .wb_en_in(wb_en_v[0]),
        .ld_valid(ld_valid_v[0]), .ld_data(ld_data_v[0]), .ld_rd(ld_rd_v[0]),
        .ld_wb_en(ld_wb_en_v[0]), .busy(busy_v[0]), .addr_err(addr_err_v[0])
    );

    fpu_dmem_responder #(.DEPTH_WORDS(256), .READ_LATENCY(2)) dut_l2 (
        .clk(clk), .rst(rst), .mem_en(mem_en_v[1]), .mem_we(mem_we_v[1]),
        .addr(addr_v[1]), .wdata(wdata_v[1]), .rd_in(rd_v[1]), .wb_en_in(wb_en_v[1]),
        .ld_valid(ld_valid_v[1]), .ld_data(ld_data_v[1]), .ld_rd(ld_rd_v[1]),
        .ld_wb_en(ld_wb_en_v[1]), .busy(busy_v[1]), .addr_err(addr_err_v[1])
    );

    fpu_dmem_responder #(.DEPTH_WORDS(256), .READ_LATENCY(8)) dut_l8 (
        .clk(clk), .rst(rst), .mem_en(mem_en_v[2]), .mem_we(mem_we_v[2]),
        .addr(addr_v[2]), .wdata(wdata_v[2]), .rd_in(rd_v[2]), .wb_en_in(wb_en_v[2]),
        .ld_valid(ld_valid_v[2]), .ld_data(ld_data_v[2]), .ld_rd(ld_rd_v[2]),
        .ld_wb_en(ld_wb_en_v[2]), .busy(busy_v[2]), .addr_err(addr_err_v[2])
    );

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 2;
            default: return 8;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Scoreboard: every ld_valid pulse must match the oldest queued load, on its due cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ld_valid_v[k] === 1'b1) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_ld_valid: inst=%0d cycle=%0d, no load outstanding", k, cyc);
                end
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_inst", k, e.k);
                    chk("resp_cycle", cyc, e.due);
                    chk("resp_data", ld_data_v[k], e.data);
                    chk("resp_rd", ld_rd_v[k], e.rd);
                    chk("resp_wb_en", ld_wb_en_v[k], e.wb);
                end
            end
        end
    end

    task automatic idle_all();
        mem_en_v = '0;
        mem_we_v = '0;
        wb_en_v  = '0;
        addr_v   = '0;
        wdata_v  = '0;
        rd_v     = '0;
    endtask

    task automatic check_reset_outputs(input int k, input string tag);
        chk({tag, "_ld_valid"}, ld_valid_v[k], 0);
        chk({tag, "_ld_data"}, ld_data_v[k], 0);
        chk({tag, "_ld_rd"}, ld_rd_v[k], 0);
        chk({tag, "_ld_wb_en"}, ld_wb_en_v[k], 0);
        chk({tag, "_addr_err"}, addr_err_v[k], 0);
        chk({tag, "_busy"}, busy_v[k], 0);
    endtask

    task automatic store(input int k, input logic [31:0] a, input logic [31:0] d);
        mem_en_v[k] = 1'b1;
        mem_we_v[k] = 1'b1;
        addr_v[k]   = a;
        wdata_v[k]  = d;
        @(negedge clk);
        mem_en_v[k] = 1'b0;
        mem_we_v[k] = 1'b0;
        chk("store_busy", busy_v[k], 0);
        chk("store_addr_err", addr_err_v[k], 0);
    endtask

    task automatic push_exp(input int k, input logic [31:0] d, input logic [4:0] rd, input logic wb);
        exp_t e;
        e.k    = k;
        e.due  = cyc + 1 + lat_of(k);
        e.data = d;
        e.rd   = rd;
        e.wb   = wb;
        sb.push_back(e);
    endtask

    // Issue a load, then count busy cycles; returns at the falling edge of the ld_valid cycle.
    task automatic load(input int k, input logic [31:0] a, input logic [4:0] rd,
                        input logic wb, input logic [31:0] d);
        int n;
        mem_en_v[k] = 1'b1;
        mem_we_v[k] = 1'b0;
        addr_v[k]   = a;
        rd_v[k]     = rd;
        wb_en_v[k]  = wb;
        push_exp(k, d, rd, wb);
        @(negedge clk);
        mem_en_v[k] = 1'b0;
        n = 0;
        while (busy_v[k] === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("busy_len", n, lat_of(k));
    endtask

    // Load followed by a store held on the bus for the whole WAIT window.
    task automatic load_with_held_store(input int k, input logic [31:0] a, input logic [4:0] rd,
                                        input logic [31:0] d, input logic [31:0] sd);
        int n;
        mem_en_v[k] = 1'b1;
        mem_we_v[k] = 1'b0;
        addr_v[k]   = a;
        rd_v[k]     = rd;
        wb_en_v[k]  = 1'b1;
        push_exp(k, d, rd, 1'b1);
        @(negedge clk);
        mem_we_v[k] = 1'b1;
        wdata_v[k]  = sd;
        n = 0;
        while (busy_v[k] === 1'b1 && n < 20) begin
            chk("held_addr_err", addr_err_v[k], 0);
            n++;
            @(negedge clk);
        end
        mem_en_v[k] = 1'b0;
        mem_we_v[k] = 1'b0;
        chk("held_busy_len", n, lat_of(k));
        chk("held_addr_err_end", addr_err_v[k], 0);
    endtask

    task automatic bad_req(input int k, input logic [31:0] a, input logic we, input logic [31:0] d);
        mem_en_v[k] = 1'b1;
        mem_we_v[k] = we;
        addr_v[k]   = a;
        wdata_v[k]  = d;
        @(negedge clk);
        mem_en_v[k] = 1'b0;
        mem_we_v[k] = 1'b0;
        chk("bad_addr_err", addr_err_v[k], 1);
        chk("bad_busy", busy_v[k], 0);
        @(negedge clk);
        chk("bad_addr_err_clear", addr_err_v[k], 0);
        chk("bad_busy_after", busy_v[k], 0);
    endtask

    // Load aborted by reset in its first WAIT cycle; nothing is queued for it.
    task automatic reset_mid_load(input int k, input logic [31:0] a);
        mem_en_v[k] = 1'b1;
        mem_we_v[k] = 1'b0;
        addr_v[k]   = a;
        rd_v[k]     = 5'd9;
        wb_en_v[k]  = 1'b1;
        @(negedge clk);
        mem_en_v[k] = 1'b0;
        chk("abort_busy_before", busy_v[k], 1);
        rst = 1'b1;
        #1;
        for (int j = 0; j < 3; j++) check_reset_outputs(j, "abort");
        @(negedge clk);
        rst = 1'b0;
        repeat (lat_of(k) + 3) @(negedge clk);
        chk("abort_busy_after", busy_v[k], 0);
        chk("abort_ld_data_after", ld_data_v[k], 0);
    endtask

    task automatic basic_and_b2b(input int k);
        store(k, 32'h10, 32'h3F80_0000);
        load(k, 32'h10, 5'd5, 1'b1, 32'h3F80_0000);
        store(k, 32'h4, 32'h1111_1111);
        store(k, 32'h8, 32'h2222_2222);
        load(k, 32'h4, 5'd1, 1'b1, 32'h1111_1111);
        load(k, 32'h8, 5'd2, 1'b1, 32'h2222_2222);
    endtask

    initial begin
        idle_all();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int j = 0; j < 3; j++) check_reset_outputs(j, "reset");
        rst = 1'b0;
        @(negedge clk);

        // Store then load, latency 2, plus back-to-back loads.
        basic_and_b2b(1);

        // Rejected requests; the out-of-range store would alias index 0 if not blocked.
        store(1, 32'h0, 32'hC000_0000);
        bad_req(1, 32'h13, 1'b0, 32'h0);
        bad_req(1, 32'h400, 1'b1, 32'h5555_5555);
        bad_req(1, 32'h2, 1'b1, 32'h6666_6666);
        load(1, 32'h0, 5'd4, 1'b0, 32'hC000_0000);

        // Store presented during WAIT must be dropped.
        store(1, 32'h20, 32'h1234_5678);
        load_with_held_store(1, 32'h20, 5'd7, 32'h1234_5678, 32'hDEAD_BEEF);
        load(1, 32'h20, 5'd8, 1'b0, 32'h1234_5678);

        // Store immediately followed by a load of the same word.
        store(1, 32'h3FC, 32'hA5A5_5A5A);
        load(1, 32'h3FC, 5'd31, 1'b1, 32'hA5A5_5A5A);

        // Reset during WAIT: load dropped, memory retained.
        reset_mid_load(1, 32'h10);
        load(1, 32'h10, 5'd3, 1'b1, 32'h3F80_0000);

        // Latency extremes.
        basic_and_b2b(0);
        basic_and_b2b(2);

        repeat (12) @(negedge clk);
        chk("outstanding_loads", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpu_dmem_responder.md
Name: fpu_dmem_responder

Overview:
Data-memory responder for the FP load/store path. Accepts the request the FPU MEM stage drives (enable, write-enable, byte address, store data, destination register, writeback enable). Stores complete in one cycle. Loads return after a parameterised latency, paired with the destination register and writeback enable for the FP writeback stage. While a load is outstanding it asserts busy so upstream stalls.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; power of two, 16..4096
READ_LATENCY, 2, clock edges from load acceptance to ld_valid assertion; 1..8

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
mem_en  in  1  request valid (load or store)
mem_we  in  1  1 = store (FSW), 0 = load (FLW); qualified by mem_en
addr  in  32  byte address
wdata  in  32  store data
rd_in  in  5  FP destination register of load
wb_en_in  in  1  writeback enable accompanying load
ld_valid  out  1  one-cycle pulse, load data valid
ld_data  out  32  load data
ld_rd  out  5  destination register returned with ld_data
ld_wb_en  out  1  writeback enable returned with ld_data
busy  out  1  load outstanding; upstream must hold its request
addr_err  out  1  one-cycle pulse, rejected request

Behaviour:
- Reset (async, rst high): state IDLE, latency counter 0. Outputs ld_valid, ld_data, ld_rd, ld_wb_en and addr_err are all 0. Memory array is NOT cleared; contents are undefined until written.
- Address decode: index = addr[log2(DEPTH_WORDS)+1:2].
- Request legality: a request is legal iff addr[1:0]==0 and addr < DEPTH_WORDS*4.
- FSM states: IDLE, WAIT.
- busy = (state==WAIT), combinational.
- IDLE, mem_en=1, illegal address:
  - no memory write, no state change.
  - addr_err=1 for exactly the next cycle.
- IDLE, mem_en=1, mem_we=1, legal: mem[index]<=wdata at that edge. No response, state stays IDLE.
- IDLE, mem_en=1, mem_we=0, legal:
  - capture index, rd_in and wb_en_in.
  - counter<=READ_LATENCY-1, go to WAIT.
- WAIT, each edge: if counter!=0, decrement. If counter==0:
  - ld_valid<=1, ld_data<=mem[captured index], ld_rd<=captured rd, ld_wb_en<=captured wb_en.
  - go to IDLE.
- Latency and busy window:
  - Load accepted at edge E0 → ld_valid high during the cycle after edge E0+READ_LATENCY.
  - busy is high for exactly READ_LATENCY cycles (after E0 through edge E0+READ_LATENCY).
- ld_valid and addr_err are single-cycle pulses; both are deasserted at every edge where they are not set.
- ld_data, ld_rd and ld_wb_en hold their last values until the next load response.
- mem_en is ignored entirely while in WAIT: no write, no capture, no addr_err.
- Back-to-back: in the cycle ld_valid is high, state is IDLE and busy=0, so a new request is accepted at the next edge. Loads issued every READ_LATENCY+1 cycles therefore sustain continuous operation.
- Store followed by load to the same address on the next edge returns the new data (write completed first).
- mem_en=0 in IDLE: no action.
- Reset asserted mid-WAIT:
  - the load is aborted, with no ld_valid now or after reset release.
  - memory contents written before reset are retained.

Test Plan:
1. Reset then store: addr=0x10, wdata=0x3F800000, mem_en=1, mem_we=1 for one cycle. Then load addr=0x10, rd_in=5, wb_en_in=1. Required: ld_valid pulses 2 edges after acceptance with ld_data=0x3F800000, ld_rd=5, ld_wb_en=1; busy high exactly 2 cycles.
2. Misaligned load addr=0x13 → addr_err pulses 1 cycle, busy stays 0, no ld_valid. Out-of-range store addr=0x400 (DEPTH 256) → addr_err pulse; a later load of 0x0 still returns its previously written value 0xC0000000.
3. Request held during WAIT: store to addr 0x20 of 0xDEADBEEF asserted while busy → ignored. Later load of 0x20 returns prior value 0x12345678.
4. Back-to-back loads of 0x4 (0x1111_1111, rd 1) and 0x8 (0x2222_2222, rd 2), second issued in the ld_valid cycle of the first. Required: two ld_valid pulses 3 cycles apart with correct data and rd.
5. Reset mid-load: rst asserted in the first WAIT cycle. Required: no ld_valid ever appears, all outputs 0. A load of 0x10 after reset returns 0x3F800000 (memory retained).
6. Repeat scenarios 1 and 4 with READ_LATENCY=1 and READ_LATENCY=8. Required: ld_valid exactly L edges after acceptance; busy high exactly L cycles.
